// File: rtl/dbus_ctrl.sv
// dbus_ctrl: memory-stage data-bus sequencer. Checks alignment, issues one dbus request
// per aligned load/store and holds the pipeline until the response word returns.
module dbus_ctrl #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic [1:0]        mem_rw,
    input  logic [2:0]        msize,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flush,
    input  logic              accept,
    output logic              dreq_valid,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [2:0]        dreq_size,
    output logic [7:0]        dreq_strobe,
    output logic [DATA_W-1:0] dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [DATA_W-1:0] dresp_data,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              stall,
    output logic              misalign
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_t;

    state_t            state;
    logic              killed;
    logic              isLoad;
    logic              isStore;
    logic              sizeBad;
    logic              launch;
    logic [7:0]        baseStrobe;
    logic [7:0]        laneStrobe;
    logic [DATA_W-1:0] laneData;
    logic              dropResp;

    always_comb begin
        isLoad  = (mem_rw == 2'b01);
        isStore = (mem_rw == 2'b10);
        case (msize)
            3'd0: begin
                sizeBad    = 1'b0;
                baseStrobe = 8'h01;
            end
            3'd1: begin
                sizeBad    = addr[0];
                baseStrobe = 8'h03;
            end
            3'd2: begin
                sizeBad    = |addr[1:0];
                baseStrobe = 8'h0F;
            end
            default: begin
                sizeBad    = |addr[2:0];
                baseStrobe = 8'hFF;
            end
        endcase
        launch     = (state == StIdle) & mem_valid & (isLoad | isStore) & ~sizeBad & ~flush;
        misalign   = (state == StIdle) & mem_valid & (isLoad | isStore) & sizeBad;
        stall      = launch | (state == StReq) | (state == StWait);
        laneStrobe = baseStrobe << addr[2:0];
        laneData   = wdata << {addr[2:0], 3'b000};
        // A flushed op still drains the bus but must not surface its data.
        dropResp   = killed | flush;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            killed      <= 1'b0;
            dreq_valid  <= 1'b0;
            dreq_addr   <= '0;
            dreq_size   <= '0;
            dreq_strobe <= '0;
            dreq_data   <= '0;
            rdata       <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (launch) begin
                        state       <= StReq;
                        dreq_valid  <= 1'b1;
                        dreq_addr   <= addr;
                        dreq_size   <= msize;
                        dreq_strobe <= isStore ? laneStrobe : 8'h00;
                        dreq_data   <= isStore ? laneData : '0;
                    end
                end
                StReq: begin
                    if (flush) killed <= 1'b1;
                    if (dresp_addr_ok) begin
                        dreq_valid <= 1'b0;
                        if (dresp_data_ok) begin
                            if (dropResp) begin
                                state  <= StIdle;
                                killed <= 1'b0;
                            end else begin
                                state <= StResp;
                                rdata <= dresp_data;
                                done  <= 1'b1;
                            end
                        end else begin
                            state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (flush) killed <= 1'b1;
                    if (dresp_data_ok) begin
                        if (dropResp) begin
                            state  <= StIdle;
                            killed <= 1'b0;
                        end else begin
                            state <= StResp;
                            rdata <= dresp_data;
                            done  <= 1'b1;
                        end
                    end
                end
                StResp: begin
                    if (accept || flush) begin
                        state <= StIdle;
                        done  <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/dbus_ctrl.md
Name: dbus_ctrl

Overview:
- Memory-stage data-bus sequencer for the pipelined RV64 core.
- Takes the load/store in the memory stage and checks alignment. Aligned ops get one dbus transaction issued with byte strobes and lane-shifted store data; misaligned ops are flagged with no request.
- Holds the pipeline until data_ok and captures the raw 64-bit read word for the load-extract logic.
- Handles flush (exception/redirect) mid-transaction without violating the bus handshake.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, bus data width (8 byte lanes).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- mem_valid  in  1  valid instruction in memory stage
- mem_rw  in  2  01 load, 10 store, 00/11 no memory op
- msize  in  3  0 byte, 1 half, 2 word, 3 dword
- addr  in  64  effective address (alu_out)
- wdata  in  64  store data, right-aligned
- flush  in  1  kill the in-flight op (exception/redirect)
- accept  in  1  pipeline advances past memory stage this cycle
- dreq_valid  out  1  dbus request valid
- dreq_addr  out  64  request address
- dreq_size  out  3  = latched msize
- dreq_strobe  out  8  byte write enables (0 for loads)
- dreq_data  out  64  lane-shifted store data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  response/data valid
- dresp_data  in  64  raw read word
- rdata  out  64  captured raw read word
- done  out  1  op complete; rdata valid for loads
- stall  out  1  freeze upstream stages
- misalign  out  1  misaligned access; combinational from inputs

Behaviour:
- Misalignment rules:
  - half: addr[0] != 0
  - word: addr[1:0] != 0
  - dword: addr[2:0] != 0
  - byte: never misaligned
  - misalign = mem_valid & mem_rw in {01,10} & rule. Asserted only in IDLE. A misaligned op issues no request, does not stall, and downstream raises code 4 (load) or 6 (store).
- Store strobe: byte 0x01, half 0x03, word 0x0F, dword 0xFF, each shifted left by addr[2:0].
- Store data: dreq_data = wdata << (8*addr[2:0]), truncated to 64 bits.
- Loads: strobe 0, dreq_data 0.
- Request fields are latched on launch and stay stable until addr_ok.
- States: IDLE, REQ, WAIT, RESP. A separate killed flag is kept.
- IDLE:
  - launch = mem_valid & memop & !misalign & !flush.
  - On launch: latch fields, go to REQ. stall=1 in the launch cycle.
- REQ:
  - dreq_valid=1. It is never dropped before addr_ok, even on flush.
  - addr_ok & data_ok: capture data, go to RESP (or IDLE if killed|flush).
  - addr_ok only: go to WAIT.
  - Neither: stay in REQ.
- WAIT:
  - dreq_valid=0.
  - data_ok: capture rdata, go to RESP (or IDLE if killed|flush).
- RESP:
  - done=1, stall=0, rdata held.
  - accept or flush: go to IDLE.
  - Otherwise stay; done remains high until then.
- killed flag:
  - Set by flush in REQ/WAIT.
  - Cleared on entry to IDLE.
  - While killed, rdata is not updated and done is never asserted.
- stall = launch | (state in {REQ, WAIT}).
- Minimum latency: launch at cycle 0, addr_ok+data_ok at cycle 1, done at cycle 2.
- data_ok received in IDLE or RESP (spurious) is ignored.
- flush in IDLE suppresses launch.
- Reset (async, any state): state=IDLE, killed=0, dreq_valid=0, dreq_addr/size/strobe/data=0, rdata=0, done=0. stall is 0 unless launch.

Test Plan:
- Aligned load, dword, addr 0x8000_0010; addr_ok+data_ok on the first REQ cycle, data 0x1122334455667788 -> dreq_valid for 1 cycle, strobe 0x00, done at cycle 2, rdata=0x1122334455667788, stall high cycles 0–1.
- Byte store, addr 0x8000_0005, wdata 0xAB; addr_ok delayed 3 cycles, data_ok 2 later -> dreq_valid held 4 cycles with stable fields, strobe 0x20, dreq_data 0x0000AB0000000000, done after data_ok.
- Misaligned word load at addr 0x8000_0002 -> misalign=1, dreq_valid stays 0, stall=0, done=0.
- Flush in REQ before addr_ok -> dreq_valid still held until addr_ok, FSM waits for data_ok then returns to IDLE. done never asserts and rdata is unchanged.
- Load completes while accept=0 for 3 cycles -> RESP holds done=1 and rdata stable; IDLE the cycle after accept; a back-to-back next op launches in that IDLE cycle.
- Async reset asserted in WAIT -> outputs clear immediately. After release a stale data_ok is ignored and a new launch works.
